// File: rtl/serial_div3_checker.sv
// rtl/serial_div3_checker.sv - MSB-first serial divisible-by-three checker
// Tracks the running residue mod 3 of an incoming bit frame and reports the result at frame end.
module serial_div3_checker #(
  parameter int MAX_BITS = 32,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_end,
  output logic             busy,
  output logic             done,
  output logic             divisible,
  output logic [1:0]       remainder,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2} residue_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BITS);

  state_t          state;
  residue_t        residue;
  residue_t        res_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic            accept;
  logic            term;

  // Shifting in b doubles the value: r' = (2r + b) mod 3. The illegal code falls back to R0.
  function automatic residue_t next_residue(input residue_t r, input logic b);
    case (r)
      R0:      return b ? R1 : R0;
      R1:      return b ? R0 : R2;
      R2:      return b ? R2 : R1;
      default: return R0;
    endcase
  endfunction

  always_comb begin
    accept  = bit_valid && (start || (state == S_RUN));
    res_nxt = start ? (bit_in ? R1 : R0) : next_residue(residue, bit_in);
    cnt_nxt = start ? CNT_W'(1) : bit_count + CNT_W'(1);
    term    = accept && (frame_end || (cnt_nxt == LAST_CNT));
  end

  assign busy = (state == S_RUN);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      residue   <= R0;
      bit_count <= '0;
      done      <= 1'b0;
      divisible <= 1'b0;
      remainder <= 2'd0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        residue   <= res_nxt;
        bit_count <= cnt_nxt;
      end else if (start) begin
        residue   <= R0;
        bit_count <= '0;
      end

      if (start) overflow <= 1'b0;

      // A start in any state aborts the current frame; the terminating bit wins over it.
      if (term) begin
        state     <= S_DONE;
        done      <= 1'b1;
        remainder <= res_nxt;
        divisible <= (res_nxt == R0);
        overflow  <= !frame_end;
      end else if (start) begin
        state <= S_RUN;
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_serial_div3_checker.sv
// tb/tb_serial_div3_checker.sv - directed table-driven bench for serial_div3_checker
module tb_serial_div3_checker;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       frame_end = 1'b0;
  logic       busy, done, divisible, overflow;
  logic [1:0] remainder;
  logic [5:0] bit_count;

  int tests = 0;
  int fails = 0;

  int         done_cnt = 0;
  logic [1:0] cap_rem = '0;
  logic       cap_div = 1'b0;
  logic       cap_ovf = 1'b0;
  logic [5:0] cap_cnt = '0;

  typedef struct {
    logic [63:0] bits;
    int          n;
    logic        fe;
    logic        gapmode;
    logic [1:0]  rem;
    logic        div;
    int          cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  serial_div3_checker #(.MAX_BITS(32), .CNT_W(6)) dut (
    .clk(clk), .RESET(RESET), .start(start), .bit_valid(bit_valid),
    .bit_in(bit_in), .frame_end(frame_end), .busy(busy), .done(done),
    .divisible(divisible), .remainder(remainder), .bit_count(bit_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      cap_rem  = remainder;
      cap_div  = divisible;
      cap_ovf  = overflow;
      cap_cnt  = bit_count;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fe);
    bit_valid = 1'b1;
    bit_in    = b;
    frame_end = fe;
    tick();
    bit_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int d0;
    int gap;
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < v.n; k++) begin
      send_bit(v.bits[v.n-1-k], v.fe && (k == v.n - 1));
      gap = v.gapmode ? (k % 4) : 0;
      if (k != v.n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk({tag, "_gap_cnt"}, 32'(bit_count), 32'(k + 1));
          chk({tag, "_gap_done"}, 32'(done), 32'd0);
          tick();
        end
      end
    end
    repeat (4) tick();
    chk({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_rem"}, 32'(cap_rem), 32'(v.rem));
    chk({tag, "_div"}, 32'(cap_div), 32'(v.div));
    chk({tag, "_cnt"}, 32'(cap_cnt), 32'(v.cnt));
    chk({tag, "_ovf"}, 32'(cap_ovf), 32'(v.ovf));
    chk({tag, "_cnt_hold"}, 32'(bit_count), 32'(v.cnt));
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_div"}, 32'(divisible), 32'd0);
    chk({tag, "_rem"}, 32'(remainder), 32'd0);
    chk({tag, "_cnt"}, 32'(bit_count), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int d0;
    vec_t v;

    vecs[0] = '{bits: 64'b110,         n: 3,  fe: 1'b1, gapmode: 1'b0, rem: 2'd0, div: 1'b1, cnt: 3,  ovf: 1'b0};
    vecs[1] = '{bits: 64'b1011,        n: 4,  fe: 1'b1, gapmode: 1'b1, rem: 2'd2, div: 1'b0, cnt: 4,  ovf: 1'b0};
    vecs[2] = '{bits: 64'b1,           n: 1,  fe: 1'b1, gapmode: 1'b0, rem: 2'd1, div: 1'b0, cnt: 1,  ovf: 1'b0};
    vecs[3] = '{bits: 64'b0,           n: 1,  fe: 1'b1, gapmode: 1'b0, rem: 2'd0, div: 1'b1, cnt: 1,  ovf: 1'b0};
    vecs[4] = '{bits: 64'b10,          n: 2,  fe: 1'b1, gapmode: 1'b0, rem: 2'd2, div: 1'b0, cnt: 2,  ovf: 1'b0};
    vecs[5] = '{bits: 64'b111,         n: 3,  fe: 1'b1, gapmode: 1'b0, rem: 2'd1, div: 1'b0, cnt: 3,  ovf: 1'b0};
    vecs[6] = '{bits: 64'b11001,       n: 5,  fe: 1'b1, gapmode: 1'b1, rem: 2'd1, div: 1'b0, cnt: 5,  ovf: 1'b0};
    vecs[7] = '{bits: 64'hFFFF_FFFF,   n: 32, fe: 1'b1, gapmode: 1'b0, rem: 2'd0, div: 1'b1, cnt: 32, ovf: 1'b0};
    vecs[8] = '{bits: 64'h1_FFFF_FFFF, n: 33, fe: 1'b0, gapmode: 1'b0, rem: 2'd0, div: 1'b1, cnt: 32, ovf: 1'b1};

    #1;
    chk_all_zero("in_reset");
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    chk_all_zero("after_reset");

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i], $sformatf("v%0d", i));
    end

    // start, bit_valid and frame_end together form a one-bit frame
    d0 = done_cnt;
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; frame_end = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0; frame_end = 1'b0;
    @(negedge clk);
    chk("one_done", 32'(done), 32'd1);
    chk("one_busy", 32'(busy), 32'd0);
    chk("one_rem", 32'(remainder), 32'd1);
    chk("one_div", 32'(divisible), 32'd0);
    chk("one_cnt", 32'(bit_count), 32'd1);
    chk("one_ovf", 32'(overflow), 32'd0);
    tick();
    @(negedge clk);
    chk("one_done_drop", 32'(done), 32'd0);
    chk("one_ndone", 32'(done_cnt - d0), 32'd1);
    tick();

    // Abort: second start discards the partial frame; results hold until the next done
    d0 = done_cnt;
    pulse_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_cnt2", 32'(bit_count), 32'd2);
    chk("abort_rem_hold", 32'(remainder), 32'd1);
    pulse_start();
    chk("abort_cnt_clr", 32'(bit_count), 32'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    repeat (4) tick();
    chk("abort_ndone", 32'(done_cnt - d0), 32'd1);
    chk("abort_rem", 32'(cap_rem), 32'd1);
    chk("abort_cnt", 32'(cap_cnt), 32'd3);

    // frame_end without bit_valid is ignored
    d0 = done_cnt;
    pulse_start();
    send_bit(1'b1, 1'b0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("fe_nobv_busy", 32'(busy), 32'd1);
    send_bit(1'b0, 1'b1);
    repeat (4) tick();
    chk("fe_nobv_ndone", 32'(done_cnt - d0), 32'd1);
    chk("fe_nobv_rem", 32'(cap_rem), 32'd2);
    chk("fe_nobv_cnt", 32'(cap_cnt), 32'd2);

    // Bits in IDLE without start are dropped
    d0 = done_cnt;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    repeat (2) tick();
    chk("idle_ndone", 32'(done_cnt - d0), 32'd0);
    chk("idle_cnt", 32'(bit_count), 32'd2);
    chk("idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a frame
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
    chk("rst_pre_cnt", 32'(bit_count), 32'd5);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2 RESET = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    RESET = 1'b0;
    repeat (3) tick();
    chk("rst_ndone", 32'(done_cnt - d0), 32'd0);
    v = vecs[0];
    run_frame(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
